irq_priority_ctrl: RTL and testbench

Vectored, prioritised interrupt controller between the peripheral interrupt sources (UART TX/RX and future blocks) and the KCPSM3 `interrupt`/`interrupt_ack` pins. It latches per-source requests, applies the firmware mask and per-source edge/level configuration, and selects one source by fixed priority. It then runs the full request/acknowledge/end-of-interrupt handshake with the CPU and exposes the active vector to the register file, so firmware reads one register instead of polling all sources.

---
 rtl/irq_priority_ctrl_pkg.sv | 36 +++
 rtl/irq_priority_ctrl_if.sv | 32 +++
 rtl/irq_prio_enc.sv | 29 ++
 rtl/irq_priority_ctrl.sv | 99 +++++++++
 tb/tb_irq_priority_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/irq_priority_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_priority_ctrl_pkg
// Brief    : Shared FSM encodings, vector layout and register-map addresses
//            for the prioritised interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package irq_priority_ctrl_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_req     = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;

    localparam int c_vec_valid_bit = 7;

    // Register-file addresses decoded by the registers block
    localparam logic [7:0] c_addr_mask    = 8'h20;
    localparam logic [7:0] c_addr_edge    = 8'h21;
    localparam logic [7:0] c_addr_clear   = 8'h22;
    localparam logic [7:0] c_addr_pending = 8'h23;
    localparam logic [7:0] c_addr_vector  = 8'h24;
    localparam logic [7:0] c_addr_eoi     = 8'h25;

    // The index bits read as zero whenever no vector is valid
    function automatic logic [7:0] make_vector(input logic valid, input logic [6:0] idx);
        logic [7:0] v;
        v = 8'h00;
        if (valid) begin
            v                   = {1'b0, idx};
            v[c_vec_valid_bit]  = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_priority_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_priority_ctrl_if
// Brief    : Source, register-file and CPU handshake signals of the
//            interrupt controller; slave = controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_priority_ctrl_if #(
    parameter int NUM_SRC = 8
);
    logic [NUM_SRC-1:0] int_src;
    logic [NUM_SRC-1:0] int_mask;
    logic [NUM_SRC-1:0] int_edge;
    logic [NUM_SRC-1:0] int_clear;
    logic               int_ack_i;
    logic               eoi_i;
    logic               int_o;
    logic [NUM_SRC-1:0] int_pending;
    logic [7:0]         int_vector;
    logic               int_active;

    modport master (
        output int_src, int_mask, int_edge, int_clear, int_ack_i, eoi_i,
        input  int_o, int_pending, int_vector, int_active
    );

    modport slave (
        input  int_src, int_mask, int_edge, int_clear, int_ack_i, eoi_i,
        output int_o, int_pending, int_vector, int_active
    );
endinterface
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Brief    : Combinational lowest-index priority encoder with any-set flag.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int VEC_W   = 3
) (
    input  wire logic [NUM_SRC-1:0] i_req,
    output logic      [VEC_W-1:0]   o_idx,
    output logic                    o_any
);

    // Scan downwards so the lowest set index is the last assignment
    always_comb begin
        o_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = VEC_W'(i);
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/irq_priority_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_priority_ctrl
// Brief    : Vectored fixed-priority interrupt controller with KCPSM3
//            request/acknowledge/EOI handshake.
// Revision : 1.0 - initial release
// ============================================================================
module irq_priority_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int VEC_W   = 3
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    irq_priority_ctrl_if.slave bus
);
    import irq_priority_ctrl_pkg::*;

    logic [NUM_SRC-1:0] r_s;
    logic [NUM_SRC-1:0] r_s_d;
    logic [NUM_SRC-1:0] r_pend;
    logic [1:0]         r_state;
    logic               r_vec_valid;
    logic [VEC_W-1:0]   r_vec_idx;

    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_eoi_clr;
    logic [NUM_SRC-1:0] w_pend_next;
    logic [NUM_SRC-1:0] w_eligible;
    logic [VEC_W-1:0]   w_win_idx;
    logic               w_win_any;

    always_comb begin
        w_set     = r_s & ~r_s_d;
        w_eoi_clr = '0;
        if ((r_state == c_st_service) && bus.eoi_i) begin
            w_eoi_clr[r_vec_idx] = 1'b1;
        end
        // Edge bits: a new rising edge outranks any clear in the same cycle
        w_pend_next = (bus.int_edge & (w_set | (r_pend & ~bus.int_clear & ~w_eoi_clr)))
                    | (~bus.int_edge & r_s);
        w_eligible  = r_pend & bus.int_mask;
    end

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) u_prio_enc (
        .i_req (w_eligible),
        .o_idx (w_win_idx),
        .o_any (w_win_any)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s         <= '0;
            r_s_d       <= '0;
            r_pend      <= '0;
            r_state     <= c_st_idle;
            r_vec_valid <= 1'b0;
            r_vec_idx   <= '0;
        end else begin
            r_s    <= bus.int_src;
            r_s_d  <= r_s;
            r_pend <= w_pend_next;
            // Vector is frozen outside IDLE: the CPU may already be committing
            case (r_state)
                c_st_idle: begin
                    if (w_win_any) begin
                        r_vec_idx   <= w_win_idx;
                        r_vec_valid <= 1'b1;
                        r_state     <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (bus.int_ack_i) begin
                        r_state <= c_st_service;
                    end
                end
                c_st_service: begin
                    if (bus.eoi_i) begin
                        r_vec_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_vec_valid <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.int_o       = (r_state == c_st_req);
    assign bus.int_active  = (r_state == c_st_service);
    assign bus.int_pending = r_pend;
    assign bus.int_vector  = make_vector(r_vec_valid, 7'(r_vec_idx));

endmodule
`default_nettype wire

// File: tb/tb_irq_priority_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_priority_ctrl
// Brief    : Directed scenarios plus randomized traffic against a
//            cycle-level behavioural model of the interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_priority_ctrl;

    localparam int NUM_SRC = 8;
    localparam int VEC_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_priority_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

    irq_priority_ctrl #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = nothing outstanding, 1 = CPU being asked, 2 = CPU servicing
    bit   m_s    [NUM_SRC];
    bit   m_sd   [NUM_SRC];
    bit   m_pend [NUM_SRC];
    int   m_phase;
    int   m_vidx;
    int   m_win;
    int   m_eoi_idx;
    bit   m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                m_s[i] = 0; m_sd[i] = 0; m_pend[i] = 0;
            end
            m_phase = 0;
            m_vidx  = 0;
            m_live  = 1'b1;
        end else begin
            m_win = -1;
            for (int i = 0; i < NUM_SRC; i++)
                if (m_win < 0 && m_pend[i] && bus.int_mask[i]) m_win = i;
            m_eoi_idx = -1;
            if (m_phase == 0 && m_win >= 0) begin
                m_phase = 1;
                m_vidx  = m_win;
            end else if (m_phase == 1 && bus.int_ack_i) begin
                m_phase = 2;
            end else if (m_phase == 2 && bus.eoi_i) begin
                m_phase   = 0;
                m_eoi_idx = m_vidx;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.int_edge[i])
                    m_pend[i] = (m_s[i] && !m_sd[i]) ||
                                (m_pend[i] && !bus.int_clear[i] && i != m_eoi_idx);
                else
                    m_pend[i] = m_s[i];
                m_sd[i] = m_s[i];
                m_s[i]  = bus.int_src[i];
            end
        end
    end

    logic [7:0] e_pend;
    logic [7:0] e_vec;

    always @(negedge clk) begin
        if (m_live) begin
            for (int i = 0; i < NUM_SRC; i++) e_pend[i] = m_pend[i];
            e_vec = (m_phase != 0) ? (8'h80 | 8'(m_vidx)) : 8'h00;
            chk("model_int_o",       bus.int_o,       32'(m_phase == 1));
            chk("model_int_active",  bus.int_active,  32'(m_phase == 2));
            chk("model_int_vector",  bus.int_vector,  e_vec);
            chk("model_int_pending", bus.int_pending, e_pend);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_int_o(input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            if (bus.int_o) break;
            tick();
        end
        chk("wait_int_o", bus.int_o, 1);
    endtask

    task automatic ack_pulse();
        bus.int_ack_i = 1'b1; tick(); bus.int_ack_i = 1'b0;
    endtask

    task automatic eoi_pulse();
        bus.eoi_i = 1'b1; tick(); bus.eoi_i = 1'b0;
    endtask

    logic [7:0] r_bits;

    initial begin
        bus.int_src = '0; bus.int_mask = '0; bus.int_edge = '0; bus.int_clear = '0;
        bus.int_ack_i = 1'b0; bus.eoi_i = 1'b0;
        rst = 1'b1;
        tick(2);
        chk("rst_int_o", bus.int_o, 0);
        chk("rst_vector", bus.int_vector, 8'h00);
        chk("rst_pending", bus.int_pending, 8'h00);
        chk("rst_active", bus.int_active, 0);
        rst = 1'b0;

        // Level source 0
        bus.int_mask = 8'hFF; bus.int_edge = 8'h00; bus.int_src = 8'h01;
        tick(); chk("lvl_o_e0", bus.int_o, 0);
        tick(); chk("lvl_pend_e1", bus.int_pending, 8'h01); chk("lvl_o_e1", bus.int_o, 0);
        tick(); chk("lvl_o_e2", bus.int_o, 1); chk("lvl_vec", bus.int_vector, 8'h80);
        ack_pulse();
        chk("lvl_ack_o", bus.int_o, 0); chk("lvl_ack_active", bus.int_active, 1);
        eoi_pulse();
        chk("lvl_eoi_active", bus.int_active, 0); chk("lvl_eoi_vec", bus.int_vector, 8'h00);
        chk("lvl_eoi_o", bus.int_o, 0);
        tick(); chk("lvl_rereq_o", bus.int_o, 1); chk("lvl_rereq_vec", bus.int_vector, 8'h80);

        // Source withdrawn during REQ, stray EOI
        bus.int_src = 8'h00;
        eoi_pulse(); tick(3);
        chk("drop_o", bus.int_o, 1); chk("drop_vec", bus.int_vector, 8'h80);
        chk("drop_active", bus.int_active, 0);
        ack_pulse(); eoi_pulse(); tick(3);
        chk("drop_idle_o", bus.int_o, 0); chk("drop_pend", bus.int_pending, 8'h00);

        // Priority between edge sources 1 and 2
        bus.int_edge = 8'hFF; tick(2);
        bus.int_src = 8'h06; tick(3);
        chk("prio_o", bus.int_o, 1); chk("prio_vec1", bus.int_vector, 8'h81);
        ack_pulse(); eoi_pulse(); tick();
        chk("prio_vec2", bus.int_vector, 8'h82); chk("prio_pend2", bus.int_pending, 8'h04);
        ack_pulse(); eoi_pulse();
        chk("prio_pend0", bus.int_pending, 8'h00); chk("prio_vec0", bus.int_vector, 8'h00);
        bus.int_src = 8'h00; tick(2);

        // Mask and clear
        bus.int_mask = 8'h00; bus.int_src = 8'h08; tick(3);
        chk("mask_pend", bus.int_pending, 8'h08); chk("mask_o", bus.int_o, 0);
        bus.int_clear = 8'h08; tick(); bus.int_clear = 8'h00;
        chk("clear_pend", bus.int_pending, 8'h00);
        bus.int_mask = 8'hFF; tick(3);
        chk("clear_no_irq", bus.int_o, 0);

        // Rising edge on source 4 coincides with its clear
        bus.int_src = 8'h18; tick();
        bus.int_clear = 8'h10; tick(); bus.int_clear = 8'h00;
        chk("set_beats_clear", bus.int_pending, 8'h10);

        // Reset in the middle of service
        wait_int_o(10);
        chk("svc_vec", bus.int_vector, 8'h84);
        ack_pulse();
        chk("svc_active", bus.int_active, 1);
        rst = 1'b1; tick(); rst = 1'b0; bus.int_src = 8'h00;
        chk("rst_svc_o", bus.int_o, 0); chk("rst_svc_active", bus.int_active, 0);
        chk("rst_svc_vec", bus.int_vector, 8'h00); chk("rst_svc_pend", bus.int_pending, 8'h00);
        tick(2);

        // Randomized traffic checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            r_bits = 8'($urandom) & 8'($urandom) & 8'($urandom);
            bus.int_src   = bus.int_src ^ r_bits;
            if ($urandom_range(0, 49) == 0) bus.int_mask = 8'($urandom);
            if ($urandom_range(0, 99) == 0) bus.int_edge = 8'($urandom);
            bus.int_clear = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            bus.int_ack_i = ($urandom_range(0, 3) == 0);
            bus.eoi_i     = ($urandom_range(0, 5) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; bus.int_ack_i = 1'b0; bus.eoi_i = 1'b0; bus.int_clear = 8'h00;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
